// File: rtl/vga_box_renderer.sv
`timescale 1ns/1ps
// vga_box_renderer: draws a bouncing coloured square behind the VGA
// timing generator and re-times sync so it stays aligned with colour.
module vga_box_renderer #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int BOX_SIZE = 100,
   parameter int STEP     = 2,
   parameter int X_INIT   = 0,
   parameter int Y_INIT   = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pix_en,
   input  logic [9:0] x_pos,
   input  logic [9:0] y_pos,
   input  logic       hsync_in,
   input  logic       vsync_in,
   input  logic       motion_en,
   output logic       vga_red,
   output logic       vga_green,
   output logic       vga_blue,
   output logic       vga_hsy,
   output logic       vga_vsy,
   output logic       bounce,
   output logic       corner_hit
);

   localparam logic [10:0] L_HA   = 11'(H_ACTIVE);
   localparam logic [10:0] L_VA   = 11'(V_ACTIVE);
   localparam logic [10:0] L_BOX  = 11'(BOX_SIZE);
   localparam logic [10:0] L_STEP = 11'(STEP);
   localparam logic [10:0] L_XMAX = 11'(H_ACTIVE - BOX_SIZE);
   localparam logic [10:0] L_YMAX = 11'(V_ACTIVE - BOX_SIZE);
   localparam logic [10:0] L_XI   = 11'(X_INIT);
   localparam logic [10:0] L_YI   = 11'(Y_INIT);
   localparam logic [2:0]  L_COL0 = 3'b100;

   // Box state; dir bit 1 = right (x) / down (y)
   logic [10:0] r_box_x;
   logic [10:0] r_box_y;
   logic        r_dir_x;
   logic        r_dir_y;
   logic [2:0]  r_col;

   // Output pipeline registers
   logic [2:0]  r_rgb;
   logic        r_hsy;
   logic        r_vsy;
   logic        r_bounce;
   logic        r_corner;

   logic [10:0] w_x;
   logic [10:0] w_y;
   logic        w_active;
   logic        w_in_box;
   logic [2:0]  w_pix;
   logic        w_tick;
   logic        w_move;
   logic [10:0] w_nx;
   logic [10:0] w_ny;
   logic        w_ndx;
   logic        w_ndy;
   logic        w_hx;
   logic        w_hy;
   logic [2:0]  w_ncol;

   // One axis of motion: clamp to the wall and turn around on a hit.
   // Returns {hit, dir, pos}.
   function automatic logic [12:0] axis_next(
      input logic [10:0] pos,
      input logic        dir,
      input logic [10:0] lim
   );
      logic [12:0] res;
      res = {1'b0, dir, pos};
      if (dir) begin
         if (pos + L_STEP >= lim) res = {1'b1, 1'b0, lim};
         else                     res = {1'b0, 1'b1, pos + L_STEP};
      end else begin
         if (pos <= L_STEP) res = {1'b1, 1'b1, 11'd0};
         else               res = {1'b0, 1'b0, pos - L_STEP};
      end
      return res;
   endfunction

   assign w_x = {1'b0, x_pos};
   assign w_y = {1'b0, y_pos};

   // Pixel colour decision for the current coordinate
   always_comb begin
      w_active = (w_x < L_HA) && (w_y < L_VA);
      w_in_box = (w_x >= r_box_x) && (w_x < r_box_x + L_BOX) &&
                 (w_y >= r_box_y) && (w_y < r_box_y + L_BOX);
      w_pix    = (w_active && w_in_box) ? r_col : 3'b000;
   end

   // Frame tick sits in blanking so the box never tears mid-frame
   always_comb begin
      w_tick = pix_en && (w_x == L_HA) && (w_y == L_VA);
      w_move = w_tick && motion_en;
   end

   // Next position, direction and wall hits for both axes
   always_comb begin
      {w_hx, w_ndx, w_nx} = axis_next(r_box_x, r_dir_x, L_XMAX);
      {w_hy, w_ndy, w_ny} = axis_next(r_box_y, r_dir_y, L_YMAX);
   end

   // Colour cycles 001..111, skipping black
   always_comb begin
      w_ncol = (r_col == 3'b111) ? 3'b001 : r_col + 3'd1;
   end

   // Render and sync pipeline, one pixel strobe deep
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rgb <= 3'b000;
         r_hsy <= 1'b1;
         r_vsy <= 1'b1;
      end else if (pix_en) begin
         r_rgb <= w_pix;
         r_hsy <= hsync_in;
         r_vsy <= vsync_in;
      end
   end

   // Box motion and colour, updated only on an enabled frame tick
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_box_x <= L_XI;
         r_box_y <= L_YI;
         r_dir_x <= 1'b1;
         r_dir_y <= 1'b1;
         r_col   <= L_COL0;
      end else if (w_move) begin
         r_box_x <= w_nx;
         r_box_y <= w_ny;
         r_dir_x <= w_ndx;
         r_dir_y <= w_ndy;
         if (w_hx || w_hy) r_col <= w_ncol;
      end
   end

   // Single-clock event pulses; cleared every cycle without a hit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bounce <= 1'b0;
         r_corner <= 1'b0;
      end else begin
         r_bounce <= w_move && (w_hx || w_hy);
         r_corner <= w_move && w_hx && w_hy;
      end
   end

   assign vga_red    = r_rgb[2];
   assign vga_green  = r_rgb[1];
   assign vga_blue   = r_rgb[0];
   assign vga_hsy    = r_hsy;
   assign vga_vsy    = r_vsy;
   assign bounce     = r_bounce;
   assign corner_hit = r_corner;

endmodule

// File: tb/tb_vga_box_renderer.sv
`timescale 1ns/1ps
// tb_vga_box_renderer: scoreboard bench for the bouncing box renderer.
// Reference box model predicts every strobe's colour, sync and pulses.
module tb_vga_box_renderer;

   logic       clk;
   logic       rst;
   logic       pix_en;
   logic [9:0] x_pos;
   logic [9:0] y_pos;
   logic       hsync_in;
   logic       vsync_in;
   logic       motion_en;
   logic       vga_red;
   logic       vga_green;
   logic       vga_blue;
   logic       vga_hsy;
   logic       vga_vsy;
   logic       bounce;
   logic       corner_hit;

   int errors;
   int checks;

   // Reference model state
   int         mbx;
   int         mby;
   bit         mdx;
   bit         mdy;
   logic [2:0] mcol;
   bit         corner_seen;
   int         motion_ticks;

   // Scoreboards: {rgb,hsy,vsy} and {bounce,corner}
   logic [4:0] q_pix[$];
   logic [1:0] q_pls[$];
   logic [4:0] last_out;

   vga_box_renderer dut (
      .clk       (clk),
      .rst       (rst),
      .pix_en    (pix_en),
      .x_pos     (x_pos),
      .y_pos     (y_pos),
      .hsync_in  (hsync_in),
      .vsync_in  (vsync_in),
      .motion_en (motion_en),
      .vga_red   (vga_red),
      .vga_green (vga_green),
      .vga_blue  (vga_blue),
      .vga_hsy   (vga_hsy),
      .vga_vsy   (vga_vsy),
      .bounce    (bounce),
      .corner_hit(corner_hit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      mbx = 0;
      mby = 0;
      mdx = 1'b1;
      mdy = 1'b1;
      mcol = 3'b100;
      q_pix.delete();
      q_pls.delete();
   endtask

   function automatic logic [2:0] model_pix(input int x, input int y);
      if (x < 640 && y < 480 && x >= mbx && x < mbx + 100 &&
          y >= mby && y < mby + 100)
         return mcol;
      return 3'b000;
   endfunction

   task automatic model_step(output bit hx, output bit hy);
      hx = 1'b0;
      hy = 1'b0;
      if (mdx) begin
         if (mbx + 2 >= 540) begin mbx = 540; mdx = 1'b0; hx = 1'b1; end
         else mbx = mbx + 2;
      end else begin
         if (mbx <= 2) begin mbx = 0; mdx = 1'b1; hx = 1'b1; end
         else mbx = mbx - 2;
      end
      if (mdy) begin
         if (mby + 2 >= 380) begin mby = 380; mdy = 1'b0; hy = 1'b1; end
         else mby = mby + 2;
      end else begin
         if (mby <= 2) begin mby = 0; mdy = 1'b1; hy = 1'b1; end
         else mby = mby - 2;
      end
      if (hx || hy) mcol = (mcol == 3'b111) ? 3'b001 : mcol + 3'd1;
   endtask

   // One pix_en strobe; expectation pushed at drive, checked one strobe on
   task automatic strobe(input int x, input int y,
                         input logic hs, input logic vs, input logic me);
      logic [4:0] ep;
      logic [4:0] got;
      logic [1:0] eb;
      logic [1:0] gb;
      bit hx;
      bit hy;
      ep = {model_pix(x, y), hs, vs};
      eb = 2'b00;
      if (x == 640 && y == 480 && me) begin
         model_step(hx, hy);
         motion_ticks++;
         eb = {hx | hy, hx & hy};
         if (hx && hy) corner_seen = 1'b1;
      end
      q_pix.push_back(ep);
      q_pls.push_back(eb);
      x_pos = 10'(x);
      y_pos = 10'(y);
      hsync_in = hs;
      vsync_in = vs;
      motion_en = me;
      pix_en = 1'b1;
      @(posedge clk);
      #1;
      pix_en = 1'b0;
      ep = q_pix.pop_front();
      eb = q_pls.pop_front();
      got = {vga_red, vga_green, vga_blue, vga_hsy, vga_vsy};
      gb = {bounce, corner_hit};
      last_out = ep;
      checks++;
      if (got !== ep) begin
         errors++;
         $display("FAIL pix(%0d,%0d) got rgbhv=%b want %b", x, y, got, ep);
      end
      checks++;
      if (gb !== eb) begin
         errors++;
         $display("FAIL pulse(%0d,%0d) got bc=%b want %b", x, y, gb, eb);
      end
   endtask

   // Frame tick followed by an idle cycle confirming the pulse is 1 clk
   task automatic tick(input logic me);
      strobe(640, 480, 1'b1, 1'b1, me);
      @(posedge clk);
      #1;
      checks++;
      if ({bounce, corner_hit} !== 2'b00) begin
         errors++;
         $display("FAIL pulse_width got bc=%b want 00", {bounce, corner_hit});
      end
   endtask

   task automatic probe_box();
      strobe(mbx, mby, 1'($urandom), 1'($urandom), 1'b0);
      strobe(mbx + 99, mby + 99, 1'b1, 1'b0, 1'b0);
      strobe(mbx + 100, mby, 1'b0, 1'b1, 1'b0);
      if (mbx > 0) strobe(mbx - 1, mby + 50, 1'b1, 1'b1, 1'b0);
      if (mby > 0) strobe(mbx + 50, mby - 1, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      pix_en = 1'b0;
      x_pos = '0;
      y_pos = '0;
      hsync_in = 1'b1;
      vsync_in = 1'b1;
      motion_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({vga_red, vga_green, vga_blue, vga_hsy, vga_vsy,
           bounce, corner_hit} !== 7'b0001100) begin
         errors++;
         $display("FAIL reset got %b want 0001100",
                  {vga_red, vga_green, vga_blue, vga_hsy, vga_vsy,
                   bounce, corner_hit});
      end
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_render();
      strobe(0, 0, 1'b1, 1'b1, 1'b0);
      strobe(99, 99, 1'b0, 1'b1, 1'b0);
      strobe(100, 0, 1'b1, 1'b0, 1'b0);
      strobe(700, 10, 1'b1, 1'b1, 1'b0);
      strobe(0, 100, 1'b1, 1'b1, 1'b0);
      strobe(50, 500, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic test_step();
      tick(1'b1);
      strobe(1, 1, 1'b1, 1'b1, 1'b0);
      strobe(2, 2, 1'b1, 1'b1, 1'b0);
      tick(1'b0);
      strobe(1, 1, 1'b1, 1'b1, 1'b0);
      strobe(2, 2, 1'b1, 1'b1, 1'b0);
      strobe(101, 101, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic test_hold();
      logic [4:0] got;
      strobe(mbx + 1, mby + 1, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         hsync_in = i[0];
         vsync_in = ~i[0];
         x_pos = 10'd700;
         y_pos = 10'd5;
         @(posedge clk);
         #1;
         got = {vga_red, vga_green, vga_blue, vga_hsy, vga_vsy};
         checks++;
         if (got !== last_out) begin
            errors++;
            $display("FAIL hold%0d got %b want %b", i, got, last_out);
         end
      end
      strobe(700, 5, 1'b0, 1'b0, 1'b0);
      strobe(mbx, mby, 1'b1, 1'b0, 1'b0);
      strobe(mbx, mby, 1'b0, 1'b1, 1'b0);
   endtask

   // Run the box until both axes hit together; probe around every bounce
   task automatic test_bounce_run();
      int n;
      bit prev_col_change;
      logic [2:0] c0;
      n = 0;
      while (!corner_seen && n < 6000) begin
         c0 = mcol;
         if (mdy && mby + 2 >= 380 && n[0]) tick(1'b0);
         tick(1'b1);
         prev_col_change = (c0 != mcol);
         if (prev_col_change || (n % 400) == 0) probe_box();
         n++;
      end
      checks++;
      if (!corner_seen) begin
         errors++;
         $display("FAIL corner_reach got ticks=%0d want corner", n);
      end
      for (int i = 0; i < 3; i++) begin
         tick(1'b1);
         probe_box();
      end
   endtask

   task automatic test_midframe_reset();
      logic [6:0] got;
      strobe(mbx + 10, mby + 10, 1'b0, 1'b0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      got = {vga_red, vga_green, vga_blue, vga_hsy, vga_vsy,
             bounce, corner_hit};
      checks++;
      if (got !== 7'b0001100) begin
         errors++;
         $display("FAIL async_reset got %b want 0001100", got);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      test_render();
      tick(1'b1);
      probe_box();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      corner_seen = 1'b0;
      motion_ticks = 0;
      last_out = '0;
      test_reset();
      test_render();
      test_step();
      test_hold();
      test_bounce_run();
      test_hold();
      test_midframe_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
